// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: circular instruction buffer between fetch and decode.
// Up to ENQ_WIDTH entries enter per cycle. The DEQ_WIDTH oldest entries are
// presented in program order. A squash empties the buffer.
// Optional macro FETCHBUF_BYPASS_EN: when the buffer is empty, enq lanes are
// forwarded onto the deq lanes in the same cycle.

// Per-lane dequeue select: stored slot or same-cycle bypass from fetch.
module fetch_inst_buffer_deq_lane #(
  parameter int W = 1
) (
  input  logic [W-1:0] slot,
  input  logic [W-1:0] byp,
  input  logic         byp_sel,
  output logic [W-1:0] data
);
  assign data = byp_sel ? byp : slot;
endmodule

module fetch_inst_buffer #(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 4,
  parameter int FTQIDX_W  = 4,
  parameter int FTQOFS_W  = 4,
  parameter int EXCEPT_W  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_squash,
  output logic                            o_can_enq,
  input  logic [ENQ_WIDTH-1:0]            i_enq_vld,
  input  logic [ENQ_WIDTH*32-1:0]         i_enq_inst,
  input  logic [ENQ_WIDTH*FTQIDX_W-1:0]   i_enq_ftq_idx,
  input  logic [ENQ_WIDTH*FTQOFS_W-1:0]   i_enq_ftq_ofs,
  input  logic [ENQ_WIDTH-1:0]            i_enq_has_except,
  input  logic [ENQ_WIDTH*EXCEPT_W-1:0]   i_enq_except,
  output logic [DEQ_WIDTH-1:0]            o_deq_vld,
  output logic [DEQ_WIDTH*32-1:0]         o_deq_inst,
  output logic [DEQ_WIDTH*FTQIDX_W-1:0]   o_deq_ftq_idx,
  output logic [DEQ_WIDTH*FTQOFS_W-1:0]   o_deq_ftq_ofs,
  output logic [DEQ_WIDTH-1:0]            o_deq_has_except,
  output logic [DEQ_WIDTH*EXCEPT_W-1:0]   o_deq_except,
  input  logic                            i_deq_rdy,
  output logic [$clog2(DEPTH):0]          o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]         inst;
    logic [FTQIDX_W-1:0] ftq_idx;
    logic [FTQOFS_W-1:0] ftq_ofs;
    logic                has_except;
    logic [EXCEPT_W-1:0] except;
  } entry_t;

  localparam int E_W = $bits(entry_t);

  entry_t mem [DEPTH];

  // Pointers carry an extra wrap bit so count == DEPTH is distinct from empty.
  logic [CNT_W-1:0] head, tail, count;
  logic [CNT_W-1:0] head_n, tail_n, cnt_n, free_n;
  logic [CNT_W-1:0] nenq, ndeq;
  logic             can_enq_q;
  logic             enq_fire, byp_act;

  entry_t [ENQ_WIDTH-1:0] enq_e;
  entry_t [DEQ_WIDTH-1:0] slot_e, byp_e, deq_e;
  logic   [DEQ_WIDTH-1:0] byp_vld, deq_vld;
  logic   [ENQ_WIDTH-1:0] wr_en;

  assign count    = tail - head;
  assign enq_fire = can_enq_q & (|i_enq_vld) & ~i_squash;

`ifdef FETCHBUF_BYPASS_EN
  assign byp_act = enq_fire & (count == '0);
`else
  assign byp_act = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ENQ_WIDTH; gi++) begin : g_enq
      assign enq_e[gi].inst       = i_enq_inst[32*gi +: 32];
      assign enq_e[gi].ftq_idx    = i_enq_ftq_idx[FTQIDX_W*gi +: FTQIDX_W];
      assign enq_e[gi].ftq_ofs    = i_enq_ftq_ofs[FTQOFS_W*gi +: FTQOFS_W];
      assign enq_e[gi].has_except = i_enq_has_except[gi];
      assign enq_e[gi].except     = i_enq_except[EXCEPT_W*gi +: EXCEPT_W];
    end

    for (gi = 0; gi < DEQ_WIDTH; gi++) begin : g_deq
      if (gi < ENQ_WIDTH) begin : g_byp
        assign byp_e[gi]   = enq_e[gi];
        assign byp_vld[gi] = i_enq_vld[gi];
      end else begin : g_nobyp
        assign byp_e[gi]   = '0;
        assign byp_vld[gi] = 1'b0;
      end
      assign slot_e[gi]  = mem[head[PTR_W-1:0] + PTR_W'(gi)];
      assign deq_vld[gi] = byp_act ? byp_vld[gi] : (count > CNT_W'(gi));

      fetch_inst_buffer_deq_lane #(.W(E_W)) u_lane (
        .slot    (slot_e[gi]),
        .byp     (byp_e[gi]),
        .byp_sel (byp_act),
        .data    (deq_e[gi])
      );

      assign o_deq_inst[32*gi +: 32]                 = deq_e[gi].inst;
      assign o_deq_ftq_idx[FTQIDX_W*gi +: FTQIDX_W]  = deq_e[gi].ftq_idx;
      assign o_deq_ftq_ofs[FTQOFS_W*gi +: FTQOFS_W]  = deq_e[gi].ftq_ofs;
      assign o_deq_has_except[gi]                    = deq_e[gi].has_except;
      assign o_deq_except[EXCEPT_W*gi +: EXCEPT_W]   = deq_e[gi].except;
    end
  endgenerate

  // Next-state pointers. Squash overrides both enq and deq.
  // Bypass-consumed lanes are never stored: head and tail both step past them.
  always_comb begin
    nenq  = '0;
    ndeq  = '0;
    wr_en = '0;
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (enq_fire && i_enq_vld[i]) nenq = nenq + CNT_W'(1);
    if (i_deq_rdy && !i_squash)
      for (int j = 0; j < DEQ_WIDTH; j++)
        if (deq_vld[j]) ndeq = ndeq + CNT_W'(1);
    for (int i = 0; i < ENQ_WIDTH; i++)
      wr_en[i] = enq_fire & i_enq_vld[i] &
                 ~(byp_act & i_deq_rdy & (i < DEQ_WIDTH));
    head_n = i_squash ? '0 : head + ndeq;
    tail_n = i_squash ? '0 : tail + nenq;
    cnt_n  = tail_n - head_n;
    free_n = CNT_W'(DEPTH) - cnt_n;
  end

  // Pointer and credit state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      can_enq_q <= 1'b1;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      can_enq_q <= (free_n >= CNT_W'(ENQ_WIDTH));
    end
  end

  // Storage write; lane i lands at tail+i modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (wr_en[i]) mem[tail[PTR_W-1:0] + PTR_W'(i)] <= enq_e[i];
  end

  assign o_can_enq = can_enq_q;
  assign o_deq_vld = deq_vld;
  assign o_count   = count;

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed bench for fetch_inst_buffer (DEPTH 16, 4 enq / 4 deq lanes).
// Expected values follow FETCHBUF_BYPASS_EN when the bench is built with it.
module tb_fetch_inst_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_squash = 1'b0;
  logic         o_can_enq;
  logic [3:0]   i_enq_vld = '0;
  logic [127:0] i_enq_inst = '0;
  logic [15:0]  i_enq_ftq_idx = '0;
  logic [15:0]  i_enq_ftq_ofs = '0;
  logic [3:0]   i_enq_has_except = '0;
  logic [19:0]  i_enq_except = '0;
  logic [3:0]   o_deq_vld;
  logic [127:0] o_deq_inst;
  logic [15:0]  o_deq_ftq_idx;
  logic [15:0]  o_deq_ftq_ofs;
  logic [3:0]   o_deq_has_except;
  logic [19:0]  o_deq_except;
  logic         i_deq_rdy = 1'b0;
  logic [4:0]   o_count;

  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;
  int noncontig_cnt = 0;

  fetch_inst_buffer dut (
    .clk(clk), .rst(rst), .i_squash(i_squash), .o_can_enq(o_can_enq),
    .i_enq_vld(i_enq_vld), .i_enq_inst(i_enq_inst),
    .i_enq_ftq_idx(i_enq_ftq_idx), .i_enq_ftq_ofs(i_enq_ftq_ofs),
    .i_enq_has_except(i_enq_has_except), .i_enq_except(i_enq_except),
    .o_deq_vld(o_deq_vld), .o_deq_inst(o_deq_inst),
    .o_deq_ftq_idx(o_deq_ftq_idx), .o_deq_ftq_ofs(o_deq_ftq_ofs),
    .o_deq_has_except(o_deq_has_except), .o_deq_except(o_deq_except),
    .i_deq_rdy(i_deq_rdy), .o_count(o_count)
  );

  always #5 clk = ~clk;

  // Protocol monitors: enqueue without credit, and non-contiguous lane valids.
  always @(posedge clk) begin
    if (rst && !o_can_enq && (|i_enq_vld) && !i_squash) begin
      ovf_cnt++;
      $display("note: enqueue attempted with o_can_enq=0 at %0t", $time);
    end
    if (rst && ((i_enq_vld & (i_enq_vld + 4'd1)) != 4'd0)) begin
      noncontig_cnt++;
      $display("note: non-contiguous i_enq_vld %b at %0t", i_enq_vld, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_enq_vld = '0;
    i_enq_has_except = '0;
    i_enq_except = '0;
    i_deq_rdy = 1'b0;
    i_squash = 1'b0;
    #1;
  endtask

  // n lanes, lane i inst = base+i, ftq_idx = idx, ofs = i.
  task automatic drive(input int n, input logic [31:0] base, input logic [3:0] idx, input logic rdy);
    for (int i = 0; i < 4; i++) begin
      i_enq_vld[i]            = (i < n);
      i_enq_inst[32*i +: 32]  = base + 32'(i);
      i_enq_ftq_idx[4*i +: 4] = idx;
      i_enq_ftq_ofs[4*i +: 4] = 4'(i);
    end
    i_enq_has_except = '0;
    i_enq_except = '0;
    i_deq_rdy = rdy;
  endtask

  task automatic do_squash();
    i_squash = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_vec++; if (o_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", o_count); end
    n_vec++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL reset_vld got %b exp 0000", o_deq_vld); end
    n_vec++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL reset_can_enq got %b exp 1", o_can_enq); end
    #2 rst = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_enq4();
    logic [31:0] exp_inst [4];
    exp_inst = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
    do_squash();
    i_enq_vld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      i_enq_inst[32*i +: 32] = exp_inst[i];
      i_enq_ftq_idx[4*i +: 4] = 4'd2;
      i_enq_ftq_ofs[4*i +: 4] = 4'(i);
    end
    tick();
    idle();
    n_vec++; if (o_deq_vld !== 4'b1111) begin n_err++; $display("FAIL enq4_vld got %b exp 1111", o_deq_vld); end
    n_vec++; if (o_count !== 5'd4) begin n_err++; $display("FAIL enq4_count got %0d exp 4", o_count); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (o_deq_inst[32*i +: 32] !== exp_inst[i]) begin
        n_err++; $display("FAIL enq4_inst lane %0d got %h exp %h", i, o_deq_inst[32*i +: 32], exp_inst[i]);
      end
    end
    n_vec++; if (o_deq_ftq_idx !== 16'h2222) begin n_err++; $display("FAIL enq4_ftq_idx got %h exp 2222", o_deq_ftq_idx); end
    n_vec++; if (o_deq_ftq_ofs !== 16'h3210) begin n_err++; $display("FAIL enq4_ftq_ofs got %h exp 3210", o_deq_ftq_ofs); end
  endtask

  task automatic test_fill();
    do_squash();
    for (int k = 0; k < 4; k++) begin
      drive(4, 32'h10000000 + 32'(k * 16), 4'(k), 1'b0);
      tick();
      idle();
      n_vec++;
      if (o_count !== 5'((k + 1) * 4)) begin n_err++; $display("FAIL fill_count step %0d got %0d exp %0d", k, o_count, (k + 1) * 4); end
      n_vec++;
      if (o_can_enq !== (k < 3)) begin n_err++; $display("FAIL fill_can_enq step %0d got %b exp %b", k, o_can_enq, (k < 3)); end
    end
    // No credit left: this enqueue must be dropped.
    drive(4, 32'hBAD00000, 4'hF, 1'b0);
    tick();
    idle();
    n_vec++; if (o_count !== 5'd16) begin n_err++; $display("FAIL full_ignored_count got %0d exp 16", o_count); end
    n_vec++; if (ovf_cnt !== 1) begin n_err++; $display("FAIL overflow_flag got %0d exp 1", ovf_cnt); end
    n_vec++; if (o_deq_inst[31:0] !== 32'h10000000) begin n_err++; $display("FAIL full_lane0 got %h exp 10000000", o_deq_inst[31:0]); end
    n_vec++; if (o_deq_vld !== 4'b1111) begin n_err++; $display("FAIL full_vld got %b exp 1111", o_deq_vld); end
    i_deq_rdy = 1'b1;
    tick();
    idle();
    n_vec++; if (o_count !== 5'd12) begin n_err++; $display("FAIL drain_count got %0d exp 12", o_count); end
    n_vec++; if (o_deq_inst[31:0] !== 32'h10000010) begin n_err++; $display("FAIL drain_lane0 got %h exp 10000010", o_deq_inst[31:0]); end
    n_vec++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL drain_can_enq got %b exp 1", o_can_enq); end
  endtask

  // Walk head to 14 with 3 entries in slots 14,15,0, then enq 4 / deq 3.
  task automatic test_wrap();
    do_squash();
    drive(4, 32'h50000100, 4'd1, 1'b0); tick(); idle();
    drive(4, 32'h50000200, 4'd1, 1'b1); tick(); idle();
    drive(4, 32'h50000300, 4'd1, 1'b1); tick(); idle();
    drive(2, 32'h50000400, 4'd1, 1'b1); tick(); idle();
    drive(3, 32'h50000500, 4'd1, 1'b1); tick(); idle();
    n_vec++; if (o_count !== 5'd3) begin n_err++; $display("FAIL wrap_pre_count got %0d exp 3", o_count); end
    n_vec++; if (o_deq_vld !== 4'b0111) begin n_err++; $display("FAIL wrap_pre_vld got %b exp 0111", o_deq_vld); end
    for (int j = 0; j < 3; j++) begin
      n_vec++;
      if (o_deq_inst[32*j +: 32] !== 32'h50000500 + 32'(j)) begin
        n_err++; $display("FAIL wrap_read lane %0d got %h exp %h", j, o_deq_inst[32*j +: 32], 32'h50000500 + 32'(j));
      end
    end
    drive(4, 32'h50000600, 4'd6, 1'b1); tick(); idle();
    n_vec++; if (o_count !== 5'd4) begin n_err++; $display("FAIL wrap_post_count got %0d exp 4", o_count); end
    for (int j = 0; j < 4; j++) begin
      n_vec++;
      if (o_deq_inst[32*j +: 32] !== 32'h50000600 + 32'(j)) begin
        n_err++; $display("FAIL wrap_post lane %0d got %h exp %h", j, o_deq_inst[32*j +: 32], 32'h50000600 + 32'(j));
      end
    end
  endtask

  task automatic test_squash();
    drive(4, 32'h70000000, 4'd7, 1'b0); tick(); idle();
    drive(1, 32'h71000000, 4'd7, 1'b0); tick(); idle();
    n_vec++; if (o_count !== 5'd9) begin n_err++; $display("FAIL squash_pre_count got %0d exp 9", o_count); end
    drive(4, 32'hDEAD0000, 4'hD, 1'b1);
    i_squash = 1'b1;
    tick();
    idle();
    n_vec++; if (o_count !== 5'd0) begin n_err++; $display("FAIL squash_count got %0d exp 0", o_count); end
    n_vec++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL squash_vld got %b exp 0000", o_deq_vld); end
    n_vec++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL squash_can_enq got %b exp 1", o_can_enq); end
    drive(1, 32'h11110000, 4'd1, 1'b0); tick(); idle();
    n_vec++; if (o_deq_vld !== 4'b0001) begin n_err++; $display("FAIL post_squash_vld got %b exp 0001", o_deq_vld); end
    n_vec++; if (o_deq_inst[31:0] !== 32'h11110000) begin n_err++; $display("FAIL post_squash_inst got %h exp 11110000", o_deq_inst[31:0]); end
    n_vec++; if (o_count !== 5'd1) begin n_err++; $display("FAIL post_squash_count got %0d exp 1", o_count); end
  endtask

  task automatic test_except();
    do_squash();
    drive(2, 32'hE0000000, 4'd3, 1'b0);
    i_enq_has_except = 4'b0010;
    i_enq_except[9:5] = 5'd12;
    #1;
`ifdef FETCHBUF_BYPASS_EN
    n_vec++; if (o_deq_vld !== 4'b0011) begin n_err++; $display("FAIL byp_vld got %b exp 0011", o_deq_vld); end
    n_vec++; if (o_deq_has_except[1] !== 1'b1 || o_deq_except[9:5] !== 5'd12) begin
      n_err++; $display("FAIL byp_except got %b/%0d exp 1/12", o_deq_has_except[1], o_deq_except[9:5]);
    end
`else
    n_vec++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL nobyp_vld got %b exp 0000", o_deq_vld); end
`endif
    tick();
    idle();
    n_vec++; if (o_deq_has_except[1:0] !== 2'b10) begin n_err++; $display("FAIL except_flag got %b exp 10", o_deq_has_except[1:0]); end
    n_vec++; if (o_deq_except[9:5] !== 5'd12) begin n_err++; $display("FAIL except_code got %0d exp 12", o_deq_except[9:5]); end
    n_vec++; if (o_count !== 5'd2) begin n_err++; $display("FAIL except_count got %0d exp 2", o_count); end
    // Enqueue into an empty buffer while decode is ready.
    do_squash();
    drive(4, 32'h80000000, 4'd8, 1'b1);
    #1;
    n_vec++;
`ifdef FETCHBUF_BYPASS_EN
    if (o_deq_inst[127:96] !== 32'h80000003) begin n_err++; $display("FAIL byp_lane3 got %h exp 80000003", o_deq_inst[127:96]); end
`else
    if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL empty_rdy_vld got %b exp 0000", o_deq_vld); end
`endif
    tick();
    idle();
    n_vec++;
`ifdef FETCHBUF_BYPASS_EN
    if (o_count !== 5'd0) begin n_err++; $display("FAIL byp_consume_count got %0d exp 0", o_count); end
`else
    if (o_count !== 5'd4) begin n_err++; $display("FAIL empty_rdy_count got %0d exp 4", o_count); end
`endif
  endtask

  task automatic test_reset_mid();
    do_squash();
    drive(4, 32'h90000000, 4'd9, 1'b0); tick(); idle();
    drive(3, 32'h91000000, 4'd9, 1'b0); tick(); idle();
    n_vec++; if (o_count !== 5'd7) begin n_err++; $display("FAIL rst_mid_pre_count got %0d exp 7", o_count); end
    #1 rst = 1'b0;
    #1;
    n_vec++; if (o_count !== 5'd0) begin n_err++; $display("FAIL rst_mid_count got %0d exp 0", o_count); end
    n_vec++; if (o_deq_vld !== 4'b0000) begin n_err++; $display("FAIL rst_mid_vld got %b exp 0000", o_deq_vld); end
    n_vec++; if (o_can_enq !== 1'b1) begin n_err++; $display("FAIL rst_mid_can_enq got %b exp 1", o_can_enq); end
    #1 rst = 1'b1;
    tick();
    n_vec++; if (noncontig_cnt !== 0) begin n_err++; $display("FAIL noncontig_flag got %0d exp 0", noncontig_cnt); end
  endtask

  initial begin
    test_reset();
    test_enq4();
    test_fill();
    test_wrap();
    test_squash();
    test_except();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
